mac_seq_ctrl: RTL and testbench

- Initiator/controller for the accumulate-only MAC datapath (a_i, b_i in; sum_o out; no clear port except its active-low reset).
- Accepts a job as a valid/ready stream of operand pairs terminated by a last flag.
- Clears the MAC, streams the pairs into it one per cycle, captures the final sum and returns it on a valid/ready result port.
- Sits between the operand source and one MAC instance in the LAB datapath.

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac.sv | 24 ++
 rtl/mac_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC datapath and its sequencer.
package mac_pkg;

  localparam int IWIDTH = 4;
  localparam int SWIDTH = 10;
  localparam int CWIDTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CAPT  = 3'd4,
    RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/mac.sv
// Accumulate-only MAC: sum_o <= sum_o + a_i*b_i every cycle, cleared only by rstn.
module mac
  import mac_pkg::*;
#(
  parameter int iwidth = IWIDTH,
  parameter int swidth = SWIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [iwidth-1:0] a_i,
  input  logic [iwidth-1:0] b_i,
  output logic [swidth-1:0] sum_o
);

  logic [2*iwidth-1:0] prod;

  assign prod = a_i * b_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sum_o <= '0;
    else       sum_o <= sum_o + swidth'(prod);
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one accumulate-only MAC: clear, stream pairs, capture sum, return result.
// Optional wrap flag res_ovf enabled by defining MAC_SEQ_OVF_EN.
//
//  state | meaning
//  IDLE  | waiting for the first pair of a job, MAC released
//  CLR   | MAC held in reset for one cycle
//  RUN   | accepting one pair per cycle
//  DRAIN | MAC absorbs the final pair
//  CAPT  | sample MAC sum into result registers
//  RESP  | result presented until accepted
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int iwidth  = IWIDTH,
  parameter int swidth  = SWIDTH,
  parameter int cwidth  = CWIDTH,
  parameter int max_len = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [iwidth-1:0] in_a,
  input  logic [iwidth-1:0] in_b,
  input  logic              in_last,
  output logic              mac_rstn_o,
  output logic [iwidth-1:0] mac_a_o,
  output logic [iwidth-1:0] mac_b_o,
  input  logic [swidth-1:0] mac_sum_i,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [swidth-1:0] res_data,
  output logic [cwidth-1:0] res_count
`ifdef MAC_SEQ_OVF_EN
  ,
  output logic              res_ovf
`endif
);

  localparam logic [cwidth-1:0] max_len_c = cwidth'(max_len);

  state_t            state;
  logic [cwidth-1:0] count;
  logic [cwidth-1:0] count_nx;
  logic              in_xfer;
  logic              job_end;

  assign in_xfer  = in_valid & in_ready;
  assign count_nx = count + 1'b1;
  assign job_end  = in_last | (count_nx == max_len_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mac_rstn_o <= 1'b0;
      mac_a_o    <= '0;
      mac_b_o    <= '0;
      in_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_count  <= '0;
      count      <= '0;
    end else begin
      // Operands default to zero so the MAC adds +0 whenever no pair is taken.
      mac_a_o <= '0;
      mac_b_o <= '0;
      case (state)
        IDLE: begin
          mac_rstn_o <= 1'b1;
          if (in_valid) begin
            mac_rstn_o <= 1'b0;
            count      <= '0;
            state      <= CLR;
          end
        end
        CLR: begin
          mac_rstn_o <= 1'b1;
          in_ready   <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (in_xfer) begin
            mac_a_o <= in_a;
            mac_b_o <= in_b;
            count   <= count_nx;
            if (job_end) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: state <= CAPT;
        CAPT: begin
          res_data  <= mac_sum_i;
          res_count <= count;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_OVF_EN
  // A product is always below 2^swidth, so a drop in the sum after a nonzero product means wrap.
  logic [swidth-1:0] sum_q;
  logic              nz_q;
  logic              ovf_q;
  logic              wrap;

  assign wrap = nz_q & (mac_sum_i < sum_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      nz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      res_ovf <= 1'b0;
    end else begin
      sum_q <= mac_sum_i;
      nz_q  <= (mac_a_o != '0) && (mac_b_o != '0);
      if (state == CLR)
        ovf_q <= 1'b0;
      else if (wrap)
        ovf_q <= 1'b1;
      if (state == CAPT)
        res_ovf <= ovf_q | wrap;
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl driving a real mac instance; checks res_ovf when MAC_SEQ_OVF_EN is defined.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IWIDTH-1:0] in_a = '0;
  logic [IWIDTH-1:0] in_b = '0;
  logic              in_last = 1'b0;
  logic              mac_rstn;
  logic [IWIDTH-1:0] mac_a;
  logic [IWIDTH-1:0] mac_b;
  logic [SWIDTH-1:0] mac_sum;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [SWIDTH-1:0] res_data;
  logic [CWIDTH-1:0] res_count;
`ifdef MAC_SEQ_OVF_EN
  logic              res_ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.iwidth(IWIDTH), .swidth(SWIDTH), .cwidth(CWIDTH), .max_len(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_rstn_o(mac_rstn), .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_sum_i(mac_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_count(res_count)
`ifdef MAC_SEQ_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  mac #(.iwidth(IWIDTH), .swidth(SWIDTH)) u_mac (
    .clk(clk), .rstn(mac_rstn), .a_i(mac_a), .b_i(mac_b), .sum_o(mac_sum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until the edge that transfers it.
  task automatic send_pair(input logic [IWIDTH-1:0] a, input logic [IWIDTH-1:0] b, input logic last);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_before_xfer", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  // Called right after the final transfer edge k; result must appear after edge k+2.
  task automatic get_result(input string tag, input int exp_data, input int exp_count,
                            input logic exp_ovf, input int hold);
    chk({tag, "_valid_k"}, res_valid, 0);
    step();
    chk({tag, "_valid_k1"}, res_valid, 0);
    step();
    chk({tag, "_valid_k2"}, res_valid, 1);
    chk({tag, "_data"}, res_data, exp_data);
    chk({tag, "_count"}, res_count, exp_count);
`ifdef MAC_SEQ_OVF_EN
    chk({tag, "_ovf"}, res_ovf, exp_ovf);
`else
    if (exp_ovf) begin end
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_data"}, res_data, exp_data);
      chk({tag, "_hold_count"}, res_count, exp_count);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_valid_after_accept"}, res_valid, 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_mac_rstn", mac_rstn, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_count", res_count, 0);
    step();
    rst = 1'b0;
    step();
    chk("idle_mac_rstn", mac_rstn, 1);
    chk("idle_in_ready", in_ready, 0);

    // 1: back-to-back job, 3*4+5*6+2*7 = 56
    send_pair(4'd3, 4'd4, 1'b0);
    send_pair(4'd5, 4'd6, 1'b0);
    send_pair(4'd2, 4'd7, 1'b1);
    get_result("t1", 56, 3, 1'b0, 0);

    // 2: same job with a 3-cycle in_valid gap
    send_pair(4'd3, 4'd4, 1'b0);
    send_pair(4'd5, 4'd6, 1'b0);
    chk("t2_mac_a_pair", mac_a, 5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_gap_mac_a", mac_a, 0);
      chk("t2_gap_mac_b", mac_b, 0);
    end
    send_pair(4'd2, 4'd7, 1'b1);
    get_result("t2", 56, 3, 1'b0, 0);

    // 3: result held under back-pressure, then a 1-pair job proves the MAC cleared
    send_pair(4'd3, 4'd4, 1'b0);
    send_pair(4'd5, 4'd6, 1'b0);
    send_pair(4'd2, 4'd7, 1'b1);
    get_result("t3", 56, 3, 1'b0, 5);
    send_pair(4'd1, 4'd1, 1'b1);
    get_result("t3b", 1, 1, 1'b0, 0);

    // 4: forced termination at 8 pairs of (1,2), remainder of 2 pairs is the next job
    for (int i = 0; i < 8; i++) send_pair(4'd1, 4'd2, 1'b0);
    get_result("t4", 16, 8, 1'b0, 0);
    send_pair(4'd1, 4'd2, 1'b0);
    send_pair(4'd1, 4'd2, 1'b1);
    get_result("t4b", 4, 2, 1'b0, 0);

    // 5: 5*225 = 1125 wraps to 101; next (2,3) job clears the wrap flag
    for (int i = 0; i < 4; i++) send_pair(4'd15, 4'd15, 1'b0);
    send_pair(4'd15, 4'd15, 1'b1);
    get_result("t5", 101, 5, 1'b1, 0);
    send_pair(4'd2, 4'd3, 1'b1);
    get_result("t5b", 6, 1, 1'b0, 0);

    // 6: reset in the middle of a job
    send_pair(4'd7, 4'd7, 1'b0);
    send_pair(4'd7, 4'd7, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_mac_rstn", mac_rstn, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_mac_a", mac_a, 0);
    chk("t6_mac_b", mac_b, 0);
    chk("t6_res_data", res_data, 0);
    chk("t6_res_count", res_count, 0);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_mac_sum", mac_sum, 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_idle_mac_rstn", mac_rstn, 1);
    send_pair(4'd4, 4'd4, 1'b1);
    get_result("t6", 16, 1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
